spike_window_decoder: RTL and testbench
=======================================

# spike_window_decoder

Serial-to-parallel receiver for the temporal spike coding used by the shifter datapath. Captures a single-wire spike stream over a fixed window of LEN cycles and rebuilds the one-hot/union spike vector, where bit t set means a spike at time stamp t. Also reports the binary time of the earliest spike, i.e. the one-hot to binary direction. Sits upstream of the shifters, feeding their Ip vectors from serial spike sources, with a valid/ready output handshake.

## Interface
- LEN, 8: window length in cycles, equal to the shifter vector length; must be ≥2.
- TW, $clog2(LEN): width of the time-stamp output; derived, not overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to open a capture window; honoured only in IDLE, or in HOLD on the handshake cycle.
- spike_in  in  1  serial spike line, sampled once per window cycle.
- busy  out  1  high in CAPTURE.
- out_valid  out  1  result available; high in HOLD.
- out_ready  in  1  consumer accepts result.
- spike_vec  out  [0:LEN-1]  captured vector; spike_vec[t] = spike_in sampled at window cycle t.
- first_time  out  TW  index of the lowest set bit of spike_vec; 0 if none.
- no_spike  out  1  spike_vec is all zero.
- spike_count  out  $clog2(LEN+1)  population count of spike_vec (only with SPIKE_COUNT_EN).

## Operation
- FSM has three states: IDLE, CAPTURE and HOLD. Reset state is IDLE.
- **IDLE**
  - On start=1, clear spike_vec, set t=0 and go to CAPTURE.
  - Otherwise stay in IDLE.
- **CAPTURE**
  - Each cycle, write spike_vec[t] ← spike_in.
  - If t==LEN-1, go to HOLD; otherwise t ← t+1.
  - start is ignored in CAPTURE.
- **HOLD**
  - Outputs are frozen.
  - If out_ready=1 and start=1 in the same cycle, clear spike_vec, set t=0 and go to CAPTURE. Back-to-back windows have no IDLE bubble.
  - If out_ready=1 and start=0, go to IDLE.
  - If out_ready=0, stay in HOLD.
- Arithmetic and width rules:
  - t counter is TW bits. The last index is LEN-1, so the counter never wraps mid-window.
  - first_time is a priority encode of spike_vec, with the lowest index winning.
  - no_spike = ~|spike_vec.
  - first_time and no_spike are registered in the same cycle as the final bit, so they are coherent with spike_vec whenever out_valid=1.
- Output stability: while out_valid=1, spike_vec, first_time, no_spike and spike_count must not change until the handshake completes.
- Outputs outside HOLD: spike_vec holds the last result or zeros and is don't-care to consumers. Verification checks these outputs only while out_valid=1.

## Timing
- Reset values of all outputs:
  - out_valid=0, busy=0.
  - spike_vec='0.
  - first_time=0, no_spike=1, spike_count=0.
  - Counter t=0.
- Cycle numbering: start is sampled at edge E0. spike_in is sampled at edges E1…E_LEN, mapping to t=0…LEN-1.
- busy is high from after E0 through E_LEN.
- out_valid rises after E_LEN. Latency from the start edge to out_valid is LEN+1 cycles.
- Handshake completes at the first edge where out_valid&&out_ready. out_valid drops after that edge unless a new window begins.
- With a back-to-back start, busy rises after that same edge.
- rst=1 at any edge, including mid-CAPTURE or in HOLD, forces IDLE and reset values at that edge. A partial window is discarded and never reported.
- rst has priority over start and out_ready.

## Configuration
- Macro: SPIKE_WINDOW_DECODER_SPIKE_COUNT_EN.
- Defined:
  - spike_count port and its popcount register exist.
  - spike_count is updated incrementally in CAPTURE: +1 per sampled spike, cleared when a window opens.
- Undefined:
  - spike_count port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package spike_pkg holds:
  - State enum typedef spike_dec_state_t {IDLE, CAPTURE, HOLD}.
  - Function clog2-safe width helper.
  - Default window length constant SPIKE_LEN_DEFAULT=8.
- One sub-module, first_spike_enc: parameterised combinational priority encoder, [0:LEN-1] to {first_time, no_spike}. It is the inverse of the binary-to-one-hot decoder used by the shifter, and can be reused there.

## Test plan
All scenarios use LEN=8.
- Single spike: start, then spike_in=1 only at t=5. Required: spike_vec=8'b0000_0100 (bit order [0:7]), first_time=5, no_spike=0, spike_count=1, out_valid after 9 cycles.
- Union spikes at t=0,1,5,6. Required: spike_vec=8'b1100_0110, first_time=0, spike_count=4.
- Empty window, all zeros. Required: no_spike=1, first_time=0, spike_count=0.
- Backpressure: hold out_ready=0 for 5 cycles while toggling spike_in and start. Required: outputs stable, out_valid stays 1, no new capture. Then assert out_ready=1 and start=1 together. Required: busy next cycle, and a second window with a spike at t=7 reports first_time=7.
- Reset mid-window: rst at t=3 of a window with spikes at t=1,2. Required: out_valid never asserts and outputs return to reset values. A subsequent window with a spike at t=4 reports first_time=4, with no stale bits.
- start during CAPTURE is ignored. Required: exactly one result, out_valid at start+9.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared definitions for the spike window decoder.
//   spike_dec_state_t  : capture FSM state encoding (IDLE, CAPTURE, HOLD)
//   SPIKE_LEN_DEFAULT  : default window length in cycles
//   clog2_safe()       : $clog2 clamped to at least 1 so derived widths never collapse to 0
package spike_pkg;

    localparam int unsigned SPIKE_LEN_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } spike_dec_state_t;

    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spike_window_decoder_first_spike_enc.sv
// first_spike_enc: combinational priority encoder, one-hot/union vector to binary time stamp.
// Lowest set index wins.
// Ports:
//   vec        in  [0:LEN-1]  spike vector, vec[t] = spike at time t
//   first_time out  TW         index of the lowest set bit, 0 when vec is empty
//   no_spike   out  1          vec is all zero
module first_spike_enc
    import spike_pkg::*;
#(
    parameter int unsigned LEN = SPIKE_LEN_DEFAULT,
    localparam int unsigned TW = clog2_safe(LEN)
) (
    input  logic [0:LEN-1] vec,
    output logic [TW-1:0]  first_time,
    output logic           no_spike
);

    always_comb begin
        first_time = '0;
        // Scan from the top down so the lowest set index is the last one written.
        for (int i = int'(LEN) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                first_time = TW'(i);
            end
        end
        no_spike = ~|vec;
    end

endmodule

// File: rtl/spike_window_decoder.sv
// spike_window_decoder: captures a serial spike stream over a LEN-cycle window and presents the
// rebuilt spike vector plus the earliest spike time behind a valid/ready handshake.
// Optional feature macro: SPIKE_WINDOW_DECODER_SPIKE_COUNT_EN adds the spike_count popcount port.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   open a window (IDLE, or HOLD on the handshake cycle)
//   spike_in     in   serial spike line, one sample per window cycle
//   busy         out  high while capturing
//   out_valid    out  result held and valid
//   out_ready    in   consumer accepts the result
//   spike_vec    out  [0:LEN-1] captured vector
//   first_time   out  index of the earliest spike, 0 if none
//   no_spike     out  captured vector is empty
//   spike_count  out  number of spikes in the window (feature macro only)
module spike_window_decoder
    import spike_pkg::*;
#(
    parameter int unsigned LEN = SPIKE_LEN_DEFAULT,
    localparam int unsigned TW = clog2_safe(LEN),
    localparam int unsigned CW = clog2_safe(LEN + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           spike_in,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [0:LEN-1] spike_vec,
    output logic [TW-1:0]  first_time,
    output logic           no_spike
`ifdef SPIKE_WINDOW_DECODER_SPIKE_COUNT_EN
    ,
    output logic [CW-1:0]  spike_count
`endif
);

    spike_dec_state_t state_q, state_d;
    logic [TW-1:0]    t_q, t_d;
    logic [0:LEN-1]   vec_q, vec_d;
    logic [TW-1:0]    first_q;
    logic             none_q;
    logic [TW-1:0]    enc_first;
    logic             enc_none;
    logic             open_win;

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        vec_d    = vec_q;
        open_win = 1'b0;
        unique case (state_q)
            IDLE: begin
                open_win = start;
            end
            CAPTURE: begin
                vec_d[t_q] = spike_in;
                if (t_q == TW'(LEN - 1)) begin
                    state_d = HOLD;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    open_win = start;
                    if (!start) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (open_win) begin
            state_d = CAPTURE;
            t_d     = '0;
            vec_d   = '0;
        end
    end

    // Encoding the next-state vector keeps first_time/no_spike coherent with spike_vec on the
    // edge that writes the final bit.
    first_spike_enc #(
        .LEN (LEN)
    ) u_enc (
        .vec        (vec_d),
        .first_time (enc_first),
        .no_spike   (enc_none)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            vec_q   <= '0;
            first_q <= '0;
            none_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            vec_q   <= vec_d;
            first_q <= enc_first;
            none_q  <= enc_none;
        end
    end

`ifdef SPIKE_WINDOW_DECODER_SPIKE_COUNT_EN
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (open_win) begin
            cnt_d = '0;
        end else if (state_q == CAPTURE && spike_in) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign spike_count = cnt_q;
`endif

    assign busy       = (state_q == CAPTURE);
    assign out_valid  = (state_q == HOLD);
    assign spike_vec  = vec_q;
    assign first_time = first_q;
    assign no_spike   = none_q;

endmodule

// File: tb/tb_spike_window_decoder.sv
// Self-checking bench for spike_window_decoder (LEN=8): directed windows from the test plan plus
// randomized windows with random backpressure, back-to-back starts and ignored start pulses.
// Expected results come from a per-window model: the spike bits as an array, earliest spike
// found by search, count by summation.
module tb_spike_window_decoder;

    localparam int LEN = 8;
    localparam int TW  = 3;
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           spike_in;
    logic           busy;
    logic           out_valid;
    logic           out_ready;
    logic [0:LEN-1] spike_vec;
    logic [TW-1:0]  first_time;
    logic           no_spike;
`ifdef SPIKE_WINDOW_DECODER_SPIKE_COUNT_EN
    logic [CW-1:0]  spike_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    spike_window_decoder #(
        .LEN (LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .spike_in   (spike_in),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .spike_vec  (spike_vec),
        .first_time (first_time),
        .no_spike   (no_spike)
`ifdef SPIKE_WINDOW_DECODER_SPIKE_COUNT_EN
        ,
        .spike_count (spike_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_first(input logic [0:LEN-1] v);
        for (int i = 0; i < LEN; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic int model_count(input logic [0:LEN-1] v);
        int s = 0;
        for (int i = 0; i < LEN; i++) s += int'(v[i]);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [0:LEN-1] v);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".vec"}, 32'(spike_vec), 32'(v));
        check_eq({tag, ".first"}, 32'(first_time), 32'(model_first(v)));
        check_eq({tag, ".none"}, 32'(no_spike), 32'(v == '0));
`ifdef SPIKE_WINDOW_DECODER_SPIKE_COUNT_EN
        check_eq({tag, ".count"}, 32'(spike_count), 32'(model_count(v)));
`endif
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".vec"}, 32'(spike_vec), 32'd0);
        check_eq({tag, ".first"}, 32'(first_time), 32'd0);
        check_eq({tag, ".none"}, 32'(no_spike), 32'd1);
`ifdef SPIKE_WINDOW_DECODER_SPIKE_COUNT_EN
        check_eq({tag, ".count"}, 32'(spike_count), 32'd0);
`endif
    endtask

    // Called just after an edge with the DUT in IDLE or HOLD. Opens a window (handshaking if in
    // HOLD), streams the bits with random ignored start pulses, checks the result, then applies
    // hold_cycles of backpressure with random start/spike_in toggling. Returns still in HOLD.
    task automatic run_window(input string tag, input logic [0:LEN-1] v, input int hold_cycles);
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        for (int k = 0; k < LEN; k++) begin
            check_eq({tag, ".busy_cap"}, 32'(busy), 32'd1);
            check_eq({tag, ".valid_cap"}, 32'(out_valid), 32'd0);
            spike_in  = v[k];
            start     = 1'($urandom);
            out_ready = 1'($urandom);
            step();
        end
        start    = 1'b0;
        spike_in = 1'b0;
        check_result(tag, v);
        for (int h = 0; h < hold_cycles; h++) begin
            out_ready = 1'b0;
            start     = 1'($urandom);
            spike_in  = 1'($urandom);
            step();
            check_result({tag, ".hold"}, v);
        end
        start    = 1'b0;
        spike_in = 1'b0;
    endtask

    task automatic release_hold(input string tag);
        out_ready = 1'b1;
        start     = 1'b0;
        step();
        check_eq({tag, ".rel_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".rel_busy"}, 32'(busy), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [0:LEN-1] v;
        int             valid_seen;

        rst       = 1'b1;
        start     = 1'b0;
        spike_in  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;
        step();
        check_reset_values("idle");

        // Single spike at t=5, exact latency check included in run_window's per-cycle checks.
        v = 8'b0000_0100;
        run_window("single", v, 0);
        release_hold("single");

        v = 8'b1100_0110;
        run_window("union", v, 0);
        release_hold("union");

        v = 8'b0000_0000;
        run_window("empty", v, 0);
        release_hold("empty");

        // Backpressure for 5 cycles, then back-to-back window with a spike at t=7.
        v = 8'b1010_0000;
        run_window("bp", v, 5);
        v = 8'b0000_0001;
        run_window("b2b", v, 0);
        release_hold("b2b");

        // Reset mid-window at t=3 with spikes at t=1,2.
        v = 8'b0110_0000;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            spike_in = v[k];
            step();
        end
        rst      = 1'b1;
        spike_in = 1'b1;
        step();
        rst      = 1'b0;
        spike_in = 1'b0;
        check_reset_values("midrst");
        valid_seen = 0;
        for (int k = 0; k < LEN + 2; k++) begin
            step();
            valid_seen += int'(out_valid);
        end
        check_eq("midrst.no_valid", 32'(valid_seen), 32'd0);
        v = 8'b0000_1000;
        run_window("postrst", v, 1);
        release_hold("postrst");

        // Randomized windows with random backpressure and random back-to-back continuation.
        for (int w = 0; w < 40; w++) begin
            v = 8'($urandom);
            if (($urandom % 4) == 0) v = '0;
            run_window("rand", v, int'($urandom_range(0, 4)));
            if (($urandom % 2) == 0) begin
                release_hold("rand");
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    step();
                    check_eq("rand.idle_valid", 32'(out_valid), 32'd0);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
